// File: rtl/lcd_hex_feeder_if.sv
// lcd_hex_feeder bus: load request, value, and the
// character/strobe/status outputs toward the LCD side.
interface lcd_hex_feeder_if;
  logic        LOAD;
  logic [63:0] DIN;
  logic [7:0]  CHAR_OUT;
  logic        CHK;
  logic        BUSY;
  logic        DONE;

  modport master (
    output LOAD,
    output DIN,
    input  CHAR_OUT,
    input  CHK,
    input  BUSY,
    input  DONE
  );

  modport slave (
    input  LOAD,
    input  DIN,
    output CHAR_OUT,
    output CHK,
    output BUSY,
    output DONE
  );
endinterface

// File: rtl/lcd_hex_feeder.sv
// lcd_hex_feeder: renders a 64-bit value as 16 ASCII hex
// characters, MSB nibble first, one strobe per character.
module lcd_hex_feeder #(
  parameter int GAP   = 4,
  parameter bit UPPER = 1'b1
) (
  input  logic             CLK,
  input  logic             RESETN,
  lcd_hex_feeder_if.slave  bus
);

  localparam logic [7:0] GAP_M1 = 8'(GAP - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] sh_q, sh_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  char_q, char_d;
  logic        chk_q, chk_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  function automatic logic [7:0] asc(
    input logic [3:0] n
  );
    logic [7:0] base;
    base = UPPER ? 8'h41 : 8'h61;
    if (n < 4'd10)
      return 8'h30 + {4'h0, n};
    else
      return base + {4'h0, n} - 8'd10;
  endfunction

  // Next state, datapath updates and registered output values
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    char_d  = char_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.LOAD) begin
          sh_d    = bus.DIN;
          idx_d   = 4'd0;
          cnt_d   = 8'd0;
          char_d  = asc(bus.DIN[63:60]);
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == GAP_M1)
          state_d = STROBE;
      end
      STROBE: begin
        if (idx_q != 4'd15) begin
          idx_d   = idx_q + 4'd1;
          sh_d    = sh_q << 4;
          char_d  = asc(sh_q[59:56]);
          cnt_d   = 8'd0;
          state_d = SETUP;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    chk_d  = (state_d == STROBE);
    busy_d = (state_d == SETUP) ||
             (state_d == STROBE);
  end

  // State and output registers; reset wins over LOAD
  always_ff @(posedge CLK) begin
    if (RESETN) begin
      state_q <= IDLE;
      sh_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      char_q  <= 8'h20;
      chk_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      char_q  <= char_d;
      chk_q   <= chk_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.CHAR_OUT = char_q;
  assign bus.CHK      = chk_q;
  assign bus.BUSY     = busy_q;
  assign bus.DONE     = done_q;

endmodule

// File: tb/tb_lcd_hex_feeder.sv
// Bench for lcd_hex_feeder: two instances (GAP=4/upper,
// GAP=1/lower) checked every cycle against a timing model.
module tb_lcd_hex_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  lcd_hex_feeder_if ifa();
  lcd_hex_feeder_if ifb();

  lcd_hex_feeder #(.GAP(4), .UPPER(1'b1)) dut_a (
    .CLK    (clk),
    .RESETN (rst_a),
    .bus    (ifa)
  );

  lcd_hex_feeder #(.GAP(1), .UPPER(1'b0)) dut_b (
    .CLK    (clk),
    .RESETN (rst_b),
    .bus    (ifb)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  typedef struct {
    bit          act;
    int          el;
    logic [63:0] d;
    logic [7:0]  ch;
    bit          done;
  } mdl_t;

  mdl_t m[2];
  int   gap_of[2] = '{4, 1};
  bit   up_of[2]  = '{1'b1, 1'b0};

  function automatic logic [7:0] ref_asc(
    input int n,
    input bit up
  );
    if (n < 10) return 8'(48 + n);
    return 8'((up ? 65 : 97) + n - 10);
  endfunction

  // el counts cycles since the first SETUP cycle
  task automatic mstep(
    input int          k,
    input logic        rst,
    input logic        ld,
    input logic [63:0] din
  );
    int          per;
    logic [63:0] t;
    per = gap_of[k] + 1;
    m[k].done = 1'b0;
    if (rst === 1'b1) begin
      m[k].act = 1'b0;
      m[k].ch  = 8'h20;
    end else if (m[k].act) begin
      m[k].el = m[k].el + 1;
      if (m[k].el == 16 * per) begin
        m[k].act  = 1'b0;
        m[k].done = 1'b1;
      end else begin
        t = m[k].d >> (4 * (15 - m[k].el / per));
        m[k].ch = ref_asc(int'(t[3:0]), up_of[k]);
      end
    end else if (ld === 1'b1) begin
      m[k].act = 1'b1;
      m[k].el  = 0;
      m[k].d   = din;
      m[k].ch  = ref_asc(int'(din[63:60]), up_of[k]);
    end
  endtask

  always @(posedge clk) begin
    mstep(0, rst_a, ifa.LOAD, ifa.DIN);
    mstep(1, rst_b, ifb.LOAD, ifb.DIN);
  end

  task automatic check_dut(
    input string      p,
    input int         k,
    input logic       chk,
    input logic       busy,
    input logic       done,
    input logic [7:0] ch
  );
    bit e_chk;
    e_chk = m[k].act &&
            (m[k].el % (gap_of[k] + 1) == gap_of[k]);
    check_eq({p, "_chk"},  32'(chk),  32'(e_chk));
    check_eq({p, "_busy"}, 32'(busy), 32'(m[k].act));
    check_eq({p, "_done"}, 32'(done), 32'(m[k].done));
    check_eq({p, "_char"}, 32'(ch),   32'(m[k].ch));
  endtask

  int chk_cnt_a = 0;
  int chk_cnt_b = 0;
  int done_cnt_a = 0;

  always @(negedge clk) begin
    check_dut("a", 0, ifa.CHK, ifa.BUSY,
              ifa.DONE, ifa.CHAR_OUT);
    check_dut("b", 1, ifb.CHK, ifb.BUSY,
              ifb.DONE, ifb.CHAR_OUT);
    if (ifa.CHK === 1'b1)  chk_cnt_a++;
    if (ifb.CHK === 1'b1)  chk_cnt_b++;
    if (ifa.DONE === 1'b1) done_cnt_a++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done_a(input int lim);
    for (int i = 0; i < lim; i++) begin
      tick();
      if (ifa.DONE === 1'b1) break;
    end
    check_eq("a_done_seen", 32'(ifa.DONE), 32'd1);
  endtask

  int c0;
  int d0;

  initial begin
    m[0] = '{1'b0, 0, 64'h0, 8'h20, 1'b0};
    m[1] = '{1'b0, 0, 64'h0, 8'h20, 1'b0};
    rst_a = 1'b1;
    rst_b = 1'b1;
    ifa.LOAD = 1'b1;
    ifa.DIN  = {$urandom, $urandom};
    ifb.LOAD = 1'b1;
    ifb.DIN  = 64'hABCDEF0000000000;

    // reset held 2 cycles with LOAD high
    repeat (2) tick();
    check_eq("a_rst_busy", 32'(ifa.BUSY), 32'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    ifa.LOAD = 1'b0;
    // B keeps LOAD high in first cycle after reset
    tick();
    ifb.LOAD = 1'b0;
    check_eq("b_started", 32'(ifb.BUSY), 32'd1);

    // nominal sequence with a busy-time load
    ifa.DIN  = 64'h0123456789ABCDEF;
    ifa.LOAD = 1'b1;
    tick();
    ifa.LOAD = 1'b0;
    c0 = chk_cnt_a;
    repeat (11) tick();
    ifa.DIN  = 64'hFFFF_FFFF_FFFF_FFFF;
    ifa.LOAD = 1'b1;
    tick();
    ifa.LOAD = 1'b0;
    wait_done_a(200);
    check_eq("a_nom_chk16", 32'(chk_cnt_a - c0), 32'd16);
    check_eq("b_lower_chk16", 32'(chk_cnt_b), 32'd16);

    // abort right after the 5th strobe
    repeat (3) tick();
    ifa.DIN  = {$urandom, $urandom};
    ifa.LOAD = 1'b1;
    tick();
    ifa.LOAD = 1'b0;
    c0 = chk_cnt_a;
    for (int i = 0; i < 100; i++) begin
      if (chk_cnt_a - c0 == 5) break;
      tick();
    end
    check_eq("a_abort_5th", 32'(chk_cnt_a - c0), 32'd5);
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    check_eq("a_abort_char", 32'(ifa.CHAR_OUT), 32'h20);
    c0 = chk_cnt_a;
    d0 = done_cnt_a;
    repeat (100) tick();
    check_eq("a_abort_nochk", 32'(chk_cnt_a - c0), 32'd0);
    check_eq("a_abort_nodone", 32'(done_cnt_a - d0), 32'd0);

    // back-to-back with LOAD held through DONE
    ifa.DIN  = 64'hDEADBEEF00000000;
    ifa.LOAD = 1'b1;
    c0 = chk_cnt_a;
    wait_done_a(200);
    tick();
    ifa.LOAD = 1'b0;
    check_eq("a_b2b_busy", 32'(ifa.BUSY), 32'd1);
    wait_done_a(200);
    check_eq("a_b2b_chk32", 32'(chk_cnt_a - c0), 32'd32);

    // random traffic on both instances
    for (int i = 0; i < 3000; i++) begin
      rst_a    = ($urandom_range(0, 299) == 0);
      rst_b    = ($urandom_range(0, 299) == 0);
      ifa.LOAD = ($urandom_range(0, 7) == 0);
      ifb.LOAD = ($urandom_range(0, 7) == 0);
      ifa.DIN  = {$urandom, $urandom};
      ifb.DIN  = {$urandom, $urandom};
      tick();
    end
    rst_a    = 1'b0;
    rst_b    = 1'b0;
    ifa.LOAD = 1'b0;
    ifb.LOAD = 1'b0;
    repeat (100) tick();

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_hex_feeder.md
LCD_HEX_FEEDER -- requirements
Module: lcd_hex_feeder

Interface
REQ-001 SHALL have parameter GAP, default 4: number of setup cycles each character is held before its strobe; legal range 1..255.
REQ-002 SHALL have parameter UPPER, default 1: 1 selects hex letters 0x41-0x46 ('A'-'F'); 0 selects 0x61-0x66 ('a'-'f').
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RESETN, input, 1 bit: reset, synchronous and active-high (1 = reset).
REQ-005 SHALL have port LOAD, input, 1 bit: request to display DIN; sampled only in IDLE.
REQ-006 SHALL have port DIN, input, 64 bits: value to be rendered as 16 hex characters.
REQ-007 SHALL have port CHAR_OUT, output, 8 bits: registered ASCII character; drives the LCD controller's line-1 data input.
REQ-008 SHALL have port CHK, output, 1 bit: registered one-cycle strobe that advances the LCD controller's line-1 character counter.
REQ-009 SHALL have port BUSY, output, 1 bit: 1 while a 16-character sequence is in progress.
REQ-010 SHALL have port DONE, output, 1 bit: one-cycle pulse when a sequence completes.

Function
REQ-011 SHALL implement states IDLE, SETUP and STROBE, with a 64-bit shift register, a 4-bit character index and an 8-bit gap counter.
REQ-012 In IDLE: CHK=0 and BUSY=0; CHAR_OUT holds its last value (0x20 after reset).
REQ-013 In IDLE, LOAD=1 at an edge SHALL capture DIN, set index=0 and counter=0, load CHAR_OUT=ascii(DIN[63:60]), and enter SETUP with BUSY=1 from the next cycle.
REQ-014 In SETUP: counter increments each cycle; when counter==GAP-1, the next state SHALL be STROBE; CHAR_OUT stays stable for the whole of SETUP.
REQ-015 In STROBE: CHK=1 for exactly that one cycle, with CHAR_OUT unchanged from SETUP.
REQ-016 On leaving STROBE with index<15: increment index, shift the register left by 4, load CHAR_OUT with the ascii of the new top nibble, clear the counter, and return to SETUP.
REQ-017 On leaving STROBE with index==15: enter IDLE, with DONE=1 and BUSY=0 in that first IDLE cycle; DONE=0 in all other cycles.
REQ-018 Character period SHALL be GAP+1 cycles; a sequence SHALL span exactly 16*(GAP+1) cycles from the first SETUP cycle to the last STROBE cycle inclusive.
REQ-019 Characters SHALL be emitted MSB nibble first (DIN[63:60] first, DIN[3:0] last).
REQ-020 Nibble mapping: 0-9 SHALL map to 0x30-0x39; 10-15 SHALL map to 0x41-0x46 when UPPER=1 and to 0x61-0x66 when UPPER=0.
REQ-021 LOAD while BUSY=1 SHALL be ignored, with no effect on the shift register, CHAR_OUT or timing; changes on DIN while busy SHALL be ignored.
REQ-022 LOAD=1 in the DONE cycle (IDLE) SHALL be accepted, starting a new sequence with no idle gap.
REQ-023 Exactly 16 CHK pulses SHALL occur per accepted LOAD, never more and never fewer unless reset intervenes.
REQ-024 Unreachable state encodings SHALL return to IDLE on the next edge with CHK=0.

Reset
REQ-025 RESETN=1 at an edge SHALL force: state=IDLE, CHK=0, BUSY=0, DONE=0, CHAR_OUT=0x20, index=0, counter=0, shift register=0.
REQ-026 Reset SHALL take priority over LOAD and over any in-progress sequence; an aborted sequence SHALL produce no further CHK and no DONE.
REQ-027 LOAD SHALL be ignored in any cycle where RESETN=1; LOAD in the first cycle after RESETN falls SHALL be accepted.

Verification
REQ-028 Reset: assert RESETN for 2 cycles with LOAD=1 -> CHK=0, BUSY=0, DONE=0, CHAR_OUT=0x20 throughout, and no sequence starts.
REQ-029 Nominal: GAP=4, UPPER=1, LOAD with DIN=0x0123456789ABCDEF -> 16 CHK pulses spaced 5 cycles apart, carrying CHAR_OUT 0x30..0x39 then 0x41..0x46, and DONE 1 cycle after the 16th CHK.
REQ-030 Busy protection: LOAD with DIN=0xFFFF_FFFF_FFFF_FFFF during the 3rd character of REQ-029 -> output sequence unchanged, still exactly 16 pulses.
REQ-031 Abort: RESETN=1 for 1 cycle right after the 5th CHK -> next cycle IDLE with CHAR_OUT=0x20, then no CHK and no DONE for 100 cycles.
REQ-032 Back-to-back: LOAD 0xDEADBEEF00000000 held high through DONE -> second sequence's first SETUP starts the cycle after DONE; the second 16 characters are correct.
REQ-033 Lowercase/min gap: UPPER=0, GAP=1, DIN=0xABCDEF0000000000 -> CHK every 2 cycles; first six characters 0x61..0x66, remaining ten 0x30.
